runner_controller: RTL and testbench
====================================

Name: runner_controller

Overview:
- Parametrised successor of the single-life player FSM, with the jump physics built in.
- Adds a lives counter, post-hit invulnerability window, multi-jump (double jump by default) and configurable jump velocity and gravity.
- Sits between the button debouncers, the collision detector and the renderer/score blocks. It is driven by the shared game_tick strobes.

Parameters:
- POS_W, 6: width of player_position (height above ground, 0 = ground).
- JUMP_VEL, 7: initial upward velocity loaded on every jump launch (unsigned, < 2^POS_W).
- GRAVITY, 1: velocity decrement per physics tick.
- LIVES, 3: lives loaded at game start (>= 1).
- INVULN_TICKS, 16: game_tick[0] count of invulnerability after a non-fatal hit.
- MAX_JUMPS, 2: launches allowed per airborne period (1 = no double jump).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- game_tick  in  2  bit0 = input/frame strobe, bit1 = physics strobe; single-cycle pulses.
- button_start  in  1  level, debounced.
- button_up  in  1  level, debounced.
- button_down  in  1  level, debounced.
- crash  in  1  collision level from the detector.
- game_state  out  3  0 RESTART, 1 JUMPING, 2 RUNNING1, 3 RUNNING2, 4 DUCKING, 5 GAME_OVER, 6 FALLING.
- player_position  out  POS_W  current height.
- lives_left  out  $clog2(LIVES+1)  remaining lives.
- invulnerable  out  1  high while the invulnerability counter is nonzero.
- game_frozen  out  1  high in RESTART or GAME_OVER.
- game_start_pulse, game_over_pulse, hit_pulse, jump_pulse  out  1 each  single-cycle event strobes.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high. While rst is high:
  - state = RESTART, position = 0, velocity = 0, lives_left = LIVES;
  - invuln counter = 0, jumps_used = 0, up_prev = 0;
  - all pulse outputs = 0.
- Reset mid-jump aborts immediately; nothing survives.
- Velocity: signed, POS_W+1 bits.
- Physics, on game_tick[1] while in JUMPING or FALLING:
  - if pos+vel <= 0: pos = 0, vel = 0, jumps_used = 0, jump_done = 1 (combinational, same cycle);
  - else pos = min(pos+vel, 2^POS_W-1), then vel -= GRAVITY (2*GRAVITY in FALLING).
  - pos stays 0 in every other state.
- Launch (jump_pulse): vel = JUMP_VEL, jumps_used += 1. The position update starts on the next game_tick[1].
- up_prev: samples button_up on every game_tick[0]. up_edge = button_up & !up_prev.
- Transitions (all registered). Crash handling has priority over everything below in the same cycle.
  - RESTART: tick0 & start -> JUMPING, with launch, game_start_pulse and jump_pulse.
  - RUNNING1/2: on tick0, checked in order:
    - down -> DUCKING;
    - up -> JUMPING with launch;
    - otherwise toggle RUNNING1/RUNNING2.
  - JUMPING:
    - tick1 & jump_done -> RUNNING1;
    - tick0 & up_edge & jumps_used < MAX_JUMPS -> relaunch (jump_pulse), stay in JUMPING.
  - DUCKING: tick0 & !down -> RUNNING1.
  - GAME_OVER: tick0 & start -> RUNNING1, with game_start_pulse. Reloads lives, pos, vel, invuln and jumps_used.
- Crash handling:
  - Active only when not frozen, invuln counter = 0 and game_tick[0] = 1.
  - lives_left > 1: lives -= 1, hit_pulse, counter = INVULN_TICKS, state unchanged (an airborne player keeps flying).
  - lives_left == 1: lives = 0, -> GAME_OVER, game_over_pulse.
  - crash while invulnerable or frozen is ignored.
- Invuln counter decrements on each game_tick[0] until it reaches 0.
- Same-tick launch and landing: landing wins; the launch is ignored.

Optional Feature:
- Macro: RUNNER_FAST_FALL_EN.
- Defined:
  - tick0 & down in JUMPING -> FALLING, with gravity doubled.
  - up_edge relaunch is still allowed in FALLING and returns the state to JUMPING.
  - Landing in FALLING -> DUCKING if down is held, else RUNNING1.
- Undefined: down is ignored while airborne, and state 6 is unreachable (the default branch maps it to RESTART).

Decomposition:
- Package runner_pkg:
  - state encodings ST_RESTART..ST_FALLING;
  - STATE_W = 3;
  - a function computing lives_left width from LIVES.
- Sub-module runner_physics (pos, vel, jumps_used, jump_done, saturation). Interface: launch, fast_fall, clear and tick1 in; pos, jump_done and can_jump out.
- The FSM, lives and invuln logic stay in the top level.

Test Plan:
- Reset, then tick0 & start -> JUMPING, jump_pulse and game_start_pulse.
  - Position over tick1s: 7,13,18,22,25,27,28,28,27,25,22,18,13,7,0.
  - The 15th tick1 -> RUNNING1.
- Double jump:
  - Airborne at pos 22, up released for one tick0 then pressed -> vel reloads to 7, next pos 29.
  - A third up_edge is ignored (MAX_JUMPS = 2).
- Lives:
  - crash at tick0 in RUNNING2 -> hit_pulse, lives 3->2, invulnerable for 16 tick0s, state RUNNING2.
  - crash held throughout that window -> no second hit.
  - crash once lives = 1 -> GAME_OVER, game_over_pulse, lives 0, game_frozen = 1.
- Restart from GAME_OVER: tick0 & start -> RUNNING1, lives = 3, pos 0, game_start_pulse = 1, jump_pulse = 0.
- Assert rst mid-jump at pos 18 without waiting for a clk edge -> pos 0, state RESTART, lives 3, all pulses 0.
- With RUNNER_FAST_FALL_EN: down at pos 25, vel 2 -> FALLING, next positions 27, 27, 25, 21. Holding down to landing -> DUCKING.

Source files
------------

// File: rtl/runner_pkg.sv
// Shared definitions for the runner controller: state encodings and sizing helpers.
package runner_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESTART   = 3'd0,
        ST_JUMPING   = 3'd1,
        ST_RUNNING1  = 3'd2,
        ST_RUNNING2  = 3'd3,
        ST_DUCKING   = 3'd4,
        ST_GAME_OVER = 3'd5,
        ST_FALLING   = 3'd6
    } state_e;

    // Width needed to hold the values 0..lives.
    function automatic int lives_w(input int lives);
        return (lives < 1) ? 1 : $clog2(lives + 1);
    endfunction

endpackage

// File: rtl/runner_physics.sv
// Vertical jump physics: height, signed velocity, per-airborne-period launch count.
// tick1 must only be asserted while the player is airborne; the top gates it.
module runner_physics #(
    parameter int POS_W     = 6,
    parameter int JUMP_VEL  = 7,
    parameter int GRAVITY   = 1,
    parameter int MAX_JUMPS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             launch,
    input  logic             fast_fall,
    input  logic             clear,
    input  logic             tick1,
    output logic [POS_W-1:0] pos,
    output logic             jump_done,
    output logic             can_jump
);

    localparam int VW = POS_W + 1;
    localparam int SW = POS_W + 2;
    localparam int JW = $clog2(MAX_JUMPS + 1);
    localparam logic signed [SW-1:0] POS_MAX = SW'(2 ** POS_W - 1);

    logic [POS_W-1:0]     pos_q, pos_d;
    logic signed [VW-1:0] vel_q, vel_d;
    logic [JW-1:0]        jumps_q, jumps_d;
    logic signed [SW-1:0] sum_s;
    logic                 land_s;

    assign sum_s  = SW'($signed({2'b00, pos_q})) + SW'(vel_q);
    // Landing when the next height would be at or below ground.
    assign land_s = tick1 && (sum_s[SW-1] || (sum_s == '0));

    assign pos       = pos_q;
    assign jump_done = land_s;
    assign can_jump  = (jumps_q < JW'(MAX_JUMPS));

    // Next height/velocity: clear and landing dominate, otherwise integrate then apply any launch.
    always_comb begin
        pos_d   = pos_q;
        vel_d   = vel_q;
        jumps_d = jumps_q;
        if (clear || land_s) begin
            pos_d   = '0;
            vel_d   = '0;
            jumps_d = '0;
        end else begin
            if (tick1) begin
                if (sum_s > POS_MAX) begin
                    pos_d = {POS_W{1'b1}};
                end else begin
                    pos_d = sum_s[POS_W-1:0];
                end
                vel_d = vel_q - VW'(fast_fall ? 2 * GRAVITY : GRAVITY);
            end else begin
                pos_d = pos_q;
            end
            if (launch) begin
                vel_d   = VW'(JUMP_VEL);
                jumps_d = jumps_q + JW'(1);
            end else begin
                jumps_d = jumps_q;
            end
        end
    end

    // Physics state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q   <= '0;
            vel_q   <= '0;
            jumps_q <= '0;
        end else begin
            pos_q   <= pos_d;
            vel_q   <= vel_d;
            jumps_q <= jumps_d;
        end
    end

endmodule

// File: rtl/runner_controller.sv
// Runner player controller: state machine, lives, post-hit invulnerability and jump physics.
// Optional build macro RUNNER_FAST_FALL_EN enables the FALLING (fast-fall) state.
module runner_controller
    import runner_pkg::*;
#(
    parameter int POS_W        = 6,
    parameter int JUMP_VEL     = 7,
    parameter int GRAVITY      = 1,
    parameter int LIVES        = 3,
    parameter int INVULN_TICKS = 16,
    parameter int MAX_JUMPS    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 game_tick,
    input  logic                       button_start,
    input  logic                       button_up,
    input  logic                       button_down,
    input  logic                       crash,
    output logic [STATE_W-1:0]         game_state,
    output logic [POS_W-1:0]           player_position,
    output logic [lives_w(LIVES)-1:0]  lives_left,
    output logic                       invulnerable,
    output logic                       game_frozen,
    output logic                       game_start_pulse,
    output logic                       game_over_pulse,
    output logic                       hit_pulse,
    output logic                       jump_pulse
);

    localparam int LW = lives_w(LIVES);
    localparam int IW = $clog2(INVULN_TICKS + 1);

    state_e        state_q, state_d;
    logic [LW-1:0] lives_q, lives_d;
    logic [IW-1:0] inv_q, inv_d;
    logic          up_prev_q, up_prev_d;
    logic          start_p_q, start_p_d;
    logic          over_p_q, over_p_d;
    logic          hit_p_q, hit_p_d;
    logic          jump_p_q, jump_p_d;

    logic tick0_s, tick1_s, frozen_s, up_edge_s, crash_hit_s, airborne_s;
    logic launch_s, clear_s, fast_fall_s, jump_done_s, can_jump_s;

    assign tick0_s   = game_tick[0];
    assign tick1_s   = game_tick[1];
    assign frozen_s  = (state_q == ST_RESTART) || (state_q == ST_GAME_OVER);
    assign up_edge_s = button_up && !up_prev_q;
    assign crash_hit_s = tick0_s && crash && !frozen_s && (inv_q == '0);

`ifdef RUNNER_FAST_FALL_EN
    assign airborne_s  = (state_q == ST_JUMPING) || (state_q == ST_FALLING);
    assign fast_fall_s = (state_q == ST_FALLING);
`else
    assign airborne_s  = (state_q == ST_JUMPING);
    assign fast_fall_s = 1'b0;
`endif

    runner_physics #(
        .POS_W     (POS_W),
        .JUMP_VEL  (JUMP_VEL),
        .GRAVITY   (GRAVITY),
        .MAX_JUMPS (MAX_JUMPS)
    ) u_physics (
        .clk       (clk),
        .rst       (rst),
        .launch    (launch_s),
        .fast_fall (fast_fall_s),
        .clear     (clear_s),
        .tick1     (tick1_s && airborne_s),
        .pos       (player_position),
        .jump_done (jump_done_s),
        .can_jump  (can_jump_s)
    );

    // Next state, lives, invulnerability and event strobes; a registered crash outranks every transition.
    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        inv_d     = (tick0_s && (inv_q != '0)) ? inv_q - IW'(1) : inv_q;
        up_prev_d = tick0_s ? button_up : up_prev_q;
        start_p_d = 1'b0;
        over_p_d  = 1'b0;
        hit_p_d   = 1'b0;
        jump_p_d  = 1'b0;
        launch_s  = 1'b0;
        clear_s   = 1'b0;
        if (crash_hit_s) begin
            if (lives_q > LW'(1)) begin
                lives_d = lives_q - LW'(1);
                hit_p_d = 1'b1;
                inv_d   = IW'(INVULN_TICKS);
            end else begin
                lives_d  = '0;
                state_d  = ST_GAME_OVER;
                over_p_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_RESTART: begin
                    if (tick0_s && button_start) begin
                        state_d   = ST_JUMPING;
                        launch_s  = 1'b1;
                        start_p_d = 1'b1;
                        jump_p_d  = 1'b1;
                    end else begin
                        state_d = ST_RESTART;
                    end
                end
                ST_RUNNING1, ST_RUNNING2: begin
                    if (!tick0_s) begin
                        state_d = state_q;
                    end else if (button_down) begin
                        state_d = ST_DUCKING;
                    end else if (button_up) begin
                        state_d  = ST_JUMPING;
                        launch_s = 1'b1;
                        jump_p_d = 1'b1;
                    end else begin
                        state_d = (state_q == ST_RUNNING1) ? ST_RUNNING2 : ST_RUNNING1;
                    end
                end
                ST_JUMPING: begin
                    if (jump_done_s) begin
                        state_d = ST_RUNNING1;
                    end else if (tick0_s && up_edge_s && can_jump_s) begin
                        launch_s = 1'b1;
                        jump_p_d = 1'b1;
`ifdef RUNNER_FAST_FALL_EN
                    end else if (tick0_s && button_down) begin
                        state_d = ST_FALLING;
`endif
                    end else begin
                        state_d = ST_JUMPING;
                    end
                end
                ST_DUCKING: begin
                    if (tick0_s && !button_down) begin
                        state_d = ST_RUNNING1;
                    end else begin
                        state_d = ST_DUCKING;
                    end
                end
                ST_GAME_OVER: begin
                    if (tick0_s && button_start) begin
                        state_d   = ST_RUNNING1;
                        start_p_d = 1'b1;
                        lives_d   = LW'(LIVES);
                        inv_d     = '0;
                        clear_s   = 1'b1;
                    end else begin
                        state_d = ST_GAME_OVER;
                    end
                end
`ifdef RUNNER_FAST_FALL_EN
                ST_FALLING: begin
                    if (jump_done_s) begin
                        state_d = button_down ? ST_DUCKING : ST_RUNNING1;
                    end else if (tick0_s && up_edge_s && can_jump_s) begin
                        state_d  = ST_JUMPING;
                        launch_s = 1'b1;
                        jump_p_d = 1'b1;
                    end else begin
                        state_d = ST_FALLING;
                    end
                end
`endif
                default: begin
                    state_d = ST_RESTART;
                end
            endcase
        end
    end

    // Controller state and registered event strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RESTART;
            lives_q   <= LW'(LIVES);
            inv_q     <= '0;
            up_prev_q <= 1'b0;
            start_p_q <= 1'b0;
            over_p_q  <= 1'b0;
            hit_p_q   <= 1'b0;
            jump_p_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            inv_q     <= inv_d;
            up_prev_q <= up_prev_d;
            start_p_q <= start_p_d;
            over_p_q  <= over_p_d;
            hit_p_q   <= hit_p_d;
            jump_p_q  <= jump_p_d;
        end
    end

    assign game_state       = state_q;
    assign lives_left       = lives_q;
    assign invulnerable     = (inv_q != '0);
    assign game_frozen      = frozen_s;
    assign game_start_pulse = start_p_q;
    assign game_over_pulse  = over_p_q;
    assign hit_pulse        = hit_p_q;
    assign jump_pulse       = jump_p_q;

endmodule

// File: tb/tb_runner_controller.sv
// Randomized scoreboard bench for runner_controller with a behavioural game model.
module tb_runner_controller;

    localparam int JV = 7, G = 1, NLIVES = 3, INV = 16, MAXJ = 2, POS_MAX = 63;
`ifdef RUNNER_FAST_FALL_EN
    localparam bit FF = 1'b1;
`else
    localparam bit FF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] game_tick = 2'b00;
    logic       button_start = 1'b0, button_up = 1'b0, button_down = 1'b0, crash = 1'b0;
    logic [2:0] game_state;
    logic [5:0] player_position;
    logic [1:0] lives_left;
    logic       invulnerable, game_frozen;
    logic       game_start_pulse, game_over_pulse, hit_pulse, jump_pulse;

    runner_controller dut (
        .clk              (clk),
        .rst              (rst),
        .game_tick        (game_tick),
        .button_start     (button_start),
        .button_up        (button_up),
        .button_down      (button_down),
        .crash            (crash),
        .game_state       (game_state),
        .player_position  (player_position),
        .lives_left       (lives_left),
        .invulnerable     (invulnerable),
        .game_frozen      (game_frozen),
        .game_start_pulse (game_start_pulse),
        .game_over_pulse  (game_over_pulse),
        .hit_pulse        (hit_pulse),
        .jump_pulse       (jump_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st; int pos; int lives; int inv; int frz; int pulses;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model state: game-level quantities in plain integers.
    int m_state, m_pos, m_vel, m_jumps, m_lives, m_inv;
    bit m_up_prev;

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_pos = 0; m_vel = 0; m_jumps = 0;
        m_lives = NLIVES; m_inv = 0; m_up_prev = 1'b0;
    endtask

    // One game step: what the player/game should look like after this tick.
    task automatic model_step(input bit t0, input bit t1, output exp_t e);
        int  ns, np, nv, nj, nl, ni;
        bit  gs, go, hit, jp, launch, land, up_edge, frozen, air;
        ns = m_state; np = m_pos; nv = m_vel; nj = m_jumps; nl = m_lives; ni = m_inv;
        gs = 0; go = 0; hit = 0; jp = 0; launch = 0; land = 0;
        frozen  = (m_state == 0) || (m_state == 5);
        air     = (m_state == 1) || (m_state == 6);
        up_edge = button_up && !m_up_prev;
        if (t0 && ni > 0) ni--;
        if (air && t1) begin
            if (m_pos + m_vel <= 0) begin
                land = 1; np = 0; nv = 0; nj = 0;
            end else begin
                np = (m_pos + m_vel > POS_MAX) ? POS_MAX : m_pos + m_vel;
                nv = m_vel - ((m_state == 6) ? 2 * G : G);
            end
        end
        if (t0 && crash && !frozen && m_inv == 0) begin
            if (m_lives > 1) begin nl = m_lives - 1; hit = 1; ni = INV; end
            else begin nl = 0; ns = 5; go = 1; end
        end else begin
            case (m_state)
                0: if (t0 && button_start) begin ns = 1; launch = 1; gs = 1; end
                2, 3: if (t0) begin
                    if (button_down) ns = 4;
                    else if (button_up) begin ns = 1; launch = 1; end
                    else ns = 5 - m_state;
                end
                1: begin
                    if (land) ns = 2;
                    else if (t0 && up_edge && m_jumps < MAXJ) launch = 1;
                    else if (FF && t0 && button_down) ns = 6;
                end
                4: if (t0 && !button_down) ns = 2;
                5: if (t0 && button_start) begin
                    ns = 2; gs = 1; nl = NLIVES; ni = 0; np = 0; nv = 0; nj = 0;
                end
                6: begin
                    if (land) ns = button_down ? 4 : 2;
                    else if (t0 && up_edge && m_jumps < MAXJ) begin ns = 1; launch = 1; end
                end
                default: ns = 0;
            endcase
        end
        if (launch) begin nv = JV; nj = m_jumps + 1; jp = 1; end
        if (t0) m_up_prev = button_up;
        m_state = ns; m_pos = np; m_vel = nv; m_jumps = nj; m_lives = nl; m_inv = ni;
        e.st = ns; e.pos = np; e.lives = nl; e.inv = (ni != 0);
        e.frz = (ns == 0 || ns == 5);
        e.pulses = {gs, go, hit, jp};
    endtask

    task automatic do_tick(input bit t0, input bit t1);
        exp_t e;
        @(negedge clk);
        game_tick = {t1, t0};
        model_step(t0, t1, e);
        exp_q.push_back(e);
        @(negedge clk);
        game_tick = 2'b00;
    endtask

    // Monitor: every edge that carried a tick strobe yields one scoreboard entry.
    always @(posedge clk) begin
        if (!rst && game_tick != 2'b00) begin
            exp_t e;
            #1;
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("state", int'(game_state), e.st);
                check("position", int'(player_position), e.pos);
                check("lives", int'(lives_left), e.lives);
                check("invulnerable", int'(invulnerable), e.inv);
                check("frozen", int'(game_frozen), e.frz);
                check("pulses", int'({game_start_pulse, game_over_pulse, hit_pulse, jump_pulse}), e.pulses);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, int'(game_state), 0);
        check({tag, "_pos"}, int'(player_position), 0);
        check({tag, "_lives"}, int'(lives_left), NLIVES);
        check({tag, "_inv"}, int'(invulnerable), 0);
        check({tag, "_frozen"}, int'(game_frozen), 1);
        check({tag, "_pulses"}, int'({game_start_pulse, game_over_pulse, hit_pulse, jump_pulse}), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int traj [15] = '{7, 13, 18, 22, 25, 27, 28, 28, 27, 25, 22, 18, 13, 7, 0};
        int guard;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // First jump from RESTART and its full trajectory.
        button_start = 1'b1;
        do_tick(1'b1, 1'b0);
        button_start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            do_tick(1'b0, 1'b1);
            check("trajectory", int'(player_position), traj[i]);
        end

        // Double jump at height 22, then a third edge that must be refused.
        button_up = 1'b1;
        do_tick(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) do_tick(1'b0, 1'b1);
        button_up = 1'b0; do_tick(1'b1, 1'b0);
        button_up = 1'b1; do_tick(1'b1, 1'b0);
        do_tick(1'b0, 1'b1);
        check("double_jump_pos", int'(player_position), 29);
        button_up = 1'b0; do_tick(1'b1, 1'b0);
        button_up = 1'b1; do_tick(1'b1, 1'b0);
        guard = 0;
        while ((m_state == 1 || m_state == 6) && guard < 200) begin
            do_tick(1'b0, 1'b1);
            guard++;
        end
        check("landing_bound", int'(guard < 200), 1);

        // Asynchronous reset in the middle of a jump.
        do_tick(1'b1, 1'b0);
        button_up = 1'b0;
        for (int i = 0; i < 3; i++) do_tick(1'b0, 1'b1);
        check("pre_reset_pos", int'(player_position), 18);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midjump_reset");
        model_reset();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Randomized play.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 2) == 0) button_up = ~button_up;
            button_down  = ($urandom_range(0, 4) == 0);
            button_start = ($urandom_range(0, 3) == 0);
            crash        = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 1) == 0) do_tick(1'b1, 1'b0);
            else do_tick(1'b0, 1'b1);
        end
        crash = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
